// File: rtl/chacha_pkg.sv
// Shared constants, FSM state type and byte-mask helper
// for the ChaCha20 stream datapath.
package chacha_pkg;

  localparam int KEY_W           = 256;
  localparam int NONCE_W         = 96;
  localparam int BLOCK_COUNT_W   = 32;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 512;
  localparam int WORDS_PER_BLOCK = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STREAM,
    ST_HALT
  } chacha_stream_state_t;

  function automatic logic [WORD_W-1:0] byte_mask(
    input logic [3:0] keep
  );
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/chacha_ks_buffer.sv
// Holds one 512-bit keystream block and selects
// the 32-bit word addressed by word_idx.
module chacha_ks_buffer
  import chacha_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int OUT_WIDTH = BLOCK_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] blk_out,
  input  logic [3:0]           word_idx,
  output logic [WIDTH-1:0]     ks_word
);

  logic [WIDTH-1:0] ks_q [WORDS_PER_BLOCK];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        ks_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        ks_q[i] <= blk_out[WIDTH*i +: WIDTH];
      end
    end
  end

  assign ks_word = ks_q[word_idx];

endmodule

// File: rtl/chacha20_stream_cipher.sv
// ChaCha20 word-stream encrypt/decrypt: sequences block requests
// with an incrementing counter and XORs keystream into the data.
module chacha20_stream_cipher
  import chacha_pkg::*;
#(
  parameter int KEY_WIDTH         = KEY_W,
  parameter int NONCE_WIDTH       = NONCE_W,
  parameter int BLOCK_COUNT_WIDTH = BLOCK_COUNT_W,
  parameter int WIDTH             = WORD_W,
  parameter int OUT_WIDTH         = BLOCK_W
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [KEY_WIDTH-1:0]         key,
  input  logic [NONCE_WIDTH-1:0]       nonce,
  input  logic [BLOCK_COUNT_WIDTH-1:0] init_count,
  input  logic                         msg_start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [3:0]                   in_keep,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [3:0]                   out_keep,
  output logic                         out_last,
  output logic                         busy,
  output logic                         count_ovf,
  output logic [KEY_WIDTH-1:0]         blk_key,
  output logic [NONCE_WIDTH-1:0]       blk_nonce,
  output logic [BLOCK_COUNT_WIDTH-1:0] blk_count,
  output logic                         blk_start,
  input  logic                         blk_ready,
  input  logic                         blk_valid,
  input  logic [OUT_WIDTH-1:0]         blk_out
);

  chacha_stream_state_t state;
  logic [3:0]           word_idx;
  logic [WIDTH-1:0]     ks_word;
  logic                 xfer;
  logic                 ks_load;
  logic [3:0]           eff_keep;

  assign in_ready  = (state == ST_STREAM) &&
                     (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;
  assign blk_start = (state == ST_REQ) && blk_ready;
  assign busy      = (state != ST_IDLE);
  assign ks_load   = (state == ST_WAIT) && blk_valid;
  // keep only trims bytes on the final word
  assign eff_keep  = in_last ? in_keep : 4'hf;

  chacha_ks_buffer #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_ks (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ks_load),
    .blk_out  (blk_out),
    .word_idx (word_idx),
    .ks_word  (ks_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      count_ovf <= 1'b0;
      blk_key   <= '0;
      blk_nonce <= '0;
      blk_count <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= (in_data ^ ks_word) & byte_mask(eff_keep);
        out_keep  <= in_keep;
        out_last  <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (msg_start) begin
            blk_key   <= key;
            blk_nonce <= nonce;
            blk_count <= init_count;
            word_idx  <= '0;
            count_ovf <= 1'b0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (blk_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (blk_valid) begin
            word_idx <= '0;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            word_idx <= word_idx + 4'd1;
            if (in_last) begin
              state <= ST_IDLE;
            end else if (word_idx == 4'hf) begin
              if (&blk_count) begin
                count_ovf <= 1'b1;
                state     <= ST_HALT;
              end else begin
                blk_count <= blk_count + 1'b1;
                state     <= ST_REQ;
              end
            end
          end
        end
        ST_HALT: begin
          if (msg_start) begin
            blk_key   <= key;
            blk_nonce <= nonce;
            blk_count <= init_count;
            word_idx  <= '0;
            count_ovf <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_stream_cipher.sv
// Directed bench for chacha20_stream_cipher with a behavioural
// ChaCha20 block-function responder and output scoreboard.
module tb_chacha20_stream_cipher;

  logic         clk = 1'b0;
  logic         resetn;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  init_count;
  logic         msg_start;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [3:0]   in_keep;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic         busy;
  logic         count_ovf;
  logic [255:0] blk_key;
  logic [95:0]  blk_nonce;
  logic [31:0]  blk_count;
  logic         blk_start;
  logic         blk_ready;
  logic         blk_valid = 1'b0;
  logic [511:0] blk_out = '0;

  always #5 clk = ~clk;

  chacha20_stream_cipher dut (
    .clk        (clk),
    .resetn     (resetn),
    .key        (key),
    .nonce      (nonce),
    .init_count (init_count),
    .msg_start  (msg_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .busy       (busy),
    .count_ovf  (count_ovf),
    .blk_key    (blk_key),
    .blk_nonce  (blk_nonce),
    .blk_count  (blk_count),
    .blk_start  (blk_start),
    .blk_ready  (blk_ready),
    .blk_valid  (blk_valid),
    .blk_out    (blk_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] qr(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] c,
                                      input logic [31:0] d);
    a += b; d ^= a; d = {d[15:0], d[31:16]};
    c += d; b ^= c; b = {b[19:0], b[31:20]};
    a += b; d ^= a; d = {d[23:0], d[31:24]};
    c += d; b ^= c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_blk(input logic [255:0] k,
                                              input logic [95:0]  n,
                                              input logic [31:0]  c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] res;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  function automatic logic [31:0] mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // block-function responder: answers each request 3 cycles later
  int           starts = 0;
  logic [31:0]  start_cnt [$];
  int           pend = 0;
  logic [511:0] pend_blk;

  always @(negedge clk) begin
    blk_valid = 1'b0;
    if (!resetn) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          blk_valid = 1'b1;
          blk_out   = pend_blk;
        end
      end
      if (blk_start) begin
        starts++;
        start_cnt.push_back(blk_count);
        pend_blk = chacha_blk(blk_key, blk_nonce, blk_count);
        pend     = 3;
      end
    end
  end

  logic [36:0] oq [$];

  always @(posedge clk) begin
    if (out_valid && out_ready) oq.push_back({out_last, out_keep, out_data});
  end

  logic [31:0] pt [64];

  task automatic send(input logic [31:0] d,
                      input logic [3:0]  k,
                      input logic        l);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    #1;
    while (!in_ready && t < 60) begin
      @(negedge clk); #1; t++;
    end
    check("send_wait", in_ready, 1'b1);
    if (in_ready) @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic start_msg(input logic [31:0] c);
    @(negedge clk);
    init_count = c; msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
    check("start_req", blk_start, 1'b1);
    check("start_cnt", blk_count, c);
  endtask

  task automatic cmp_out(input string tag, input int base,
                         input int n, input logic [31:0] c0,
                         input logic [3:0] lkeep,
                         input logic llast);
    logic [511:0] b;
    logic [31:0]  ks;
    logic         lst;
    logic [3:0]   kp;
    check({tag, "_cnt"}, oq.size() - base, n);
    for (int i = 0; i < n; i++) begin
      b   = chacha_blk(key, nonce, c0 + i / 16);
      ks  = b[32*(i%16) +: 32];
      lst = llast && (i == n - 1);
      kp  = lst ? lkeep : 4'hf;
      if (base + i < oq.size())
        check(tag, oq[base+i], {lst, kp, (pt[i] ^ ks) & mask(kp)});
    end
  endtask

  string       rfc;
  int          base, sb, nw, rem;
  logic [3:0]  lkeep;
  logic [31:0] hold;
  logic [511:0] kb;
  logic [7:0]  ch;

  initial begin
    resetn = 1'b0; msg_start = 1'b0; in_valid = 1'b0;
    in_data = '0; in_keep = '0; in_last = 1'b0;
    out_ready = 1'b1; blk_ready = 1'b1; init_count = '0;
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    nonce = 96'h00000000_4a000000_00000000;
    rfc = {"Ladies and Gentlemen of the class of '99: If I could ",
           "offer you only one tip for the future, sunscreen would be it."};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_blk_start", blk_start, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", count_ovf, 0);
    check("rst_blk", {|blk_key, |blk_nonce, |blk_count}, 0);
    @(negedge clk) resetn = 1'b1;

    // RFC 8439 2.4.2 vector with a backpressure stall
    for (int i = 0; i < 64; i++) pt[i] = '0;
    for (int i = 0; i < rfc.len(); i++) begin
      ch = rfc[i];
      pt[i/4][8*(i%4) +: 8] = ch;
    end
    nw    = (rfc.len() + 3) / 4;
    rem   = rfc.len() % 4;
    lkeep = (rem == 0) ? 4'hf : 4'((1 << rem) - 1);
    base  = oq.size();
    sb    = starts;
    start_msg(32'd1);
    check("rfc_nonce", blk_nonce[63:32], 32'h4a000000);
    for (int i = 0; i < nw; i++) begin
      if (i == 5) begin
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = pt[5];
        in_keep = 4'hf;
        #1 hold = out_data;
        kb = chacha_blk(key, nonce, 32'd1);
        check("bp_word4", hold, pt[4] ^ kb[32*4 +: 32]);
        repeat (5) begin
          @(negedge clk); #1;
          check("bp_in_ready", in_ready, 0);
          check("bp_hold", out_data, hold);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
      end
      send(pt[i], (i == nw - 1) ? lkeep : 4'hf, i == nw - 1);
      if (i == 15) begin
        check("bound_in_ready", in_ready, 0);
        check("bound_busy", busy, 1);
      end
    end
    repeat (4) @(negedge clk);
    check("rfc_first", oq[base][31:0], 32'h9a352e6e);
    check("rfc_last_keep", oq[base+nw-1][35:32], 4'b0011);
    cmp_out("rfc", base, nw, 32'd1, lkeep, 1'b1);
    check("roll_starts", starts - sb, 2);
    check("roll_cnt0", start_cnt[sb], 1);
    check("roll_cnt1", start_cnt[sb+1], 2);
    kb = chacha_blk(key, nonce, 32'd2);
    check("roll_w16", oq[base+16][31:0], pt[16] ^ kb[31:0]);

    // counter overflow
    for (int i = 0; i < 17; i++) pt[i] = 32'hA5A50000 ^ (32'h01010101 * i);
    base = oq.size();
    sb   = starts;
    start_msg(32'hffffffff);
    for (int i = 0; i < 16; i++) send(pt[i], 4'hf, 1'b0);
    check("ovf_flag", count_ovf, 1);
    check("ovf_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1; in_data = pt[16]; in_keep = 4'hf;
    repeat (8) @(negedge clk);
    #1;
    check("ovf_hold_ready", in_ready, 0);
    check("ovf_busy", busy, 1);
    check("ovf_starts", starts - sb, 1);
    check("ovf_cnt", blk_count, 32'hffffffff);
    in_valid = 1'b0;
    cmp_out("ovf", base, 16, 32'hffffffff, 4'hf, 1'b0);
    @(negedge clk) msg_start = 1'b1;
    @(negedge clk) msg_start = 1'b0;
    check("halt_exit_ovf", count_ovf, 0);
    repeat (2) @(negedge clk);

    // reset mid-stream
    for (int i = 0; i < 8; i++) pt[i] = 32'h3c3c0000 + 32'(i * 7);
    start_msg(32'd5);
    for (int i = 0; i < 7; i++) send(pt[i], 4'hf, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = pt[7]; in_keep = 4'hf;
    resetn = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out", {out_last, out_keep, out_data}, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_blk", {blk_start, |blk_key, |blk_count}, 0);
    in_valid = 1'b0;
    @(negedge clk) resetn = 1'b1;
    base = oq.size();
    start_msg(32'd9);
    send(pt[0], 4'hf, 1'b0);
    send(pt[1], 4'hf, 1'b0);
    repeat (3) @(negedge clk);
    cmp_out("restart", base, 2, 32'd9, 4'hf, 1'b0);

    // reset left the message open; restart fresh for the last test
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;

    // in_last on word 15
    for (int i = 0; i < 16; i++) pt[i] = 32'hdeadbeef ^ 32'(i << 4);
    base = oq.size();
    sb   = starts;
    start_msg(32'd3);
    for (int i = 0; i < 16; i++) send(pt[i], 4'hf, i == 15);
    check("l15_busy", busy, 0);
    check("l15_blk_start", blk_start, 0);
    check("l15_cnt", blk_count, 3);
    repeat (6) @(negedge clk);
    check("l15_starts", starts - sb, 1);
    cmp_out("l15", base, 16, 32'd3, 4'hf, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
